inst_aligner: RTL and testbench
===============================

// Module: inst_aligner
// PURPOSE
//  Fetch-side halfword queue between instruction memory and the IF/ID register in the RV32IMC pipeline.
//  Fetches sequential 32-bit words and re-aligns them into whole 16-bit (compressed) or 32-bit instructions,
//  including 32-bit instructions that straddle a word boundary.
//  Delivers the instruction, its PC and a compressed flag to IF.
//  Raises buffer_stall to the stall/flush controller when it cannot present a complete instruction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  byte PC loaded on reset
//  ADDR_W    12             instruction-memory word-address width
//  DEPTH     4              queue capacity in halfwords; even, >= 4
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  nrst          in   1       reset; synchronous, active-high
//  if_en         in   1       IF advance enable; 1 = consume the presented instruction
//  flush         in   1       redirect (taken branch or jump); priority over all other events
//  flush_target  in   32      redirect byte address; bit 0 ignored
//  imem_en       out  1       word read request; data returns on imem_rdata one cycle later
//  imem_addr     out  ADDR_W  word address of the request
//  imem_rdata    in   32      read data for the request issued in the previous cycle
//  if_inst       out  32      presented instruction; compressed form is {16'h0, hw}
//  if_pc         out  32      byte PC of if_inst
//  if_is_c       out  1       1 = if_inst is 16-bit (head hw[1:0] != 2'b11)
//  buffer_stall  out  1       1 = no complete instruction available; if_inst/if_pc/if_is_c are don't-care
// BEHAVIOUR
//  State:
//   - q[DEPTH] halfword queue: head = oldest, with count.
//   - fetch_wa: next word address.
//   - inflight: a request is outstanding.
//   - skip: drop the low halfword of the next response.
//   - pc_r: PC of the head halfword.
//  Reset values:
//   - count = 0, inflight = 0, skip = 0, pc_r = RESET_PC, fetch_wa = RESET_PC[ADDR_W+1:2].
//   - Outputs: buffer_stall = 1, imem_en = 0 in the reset cycle, if_pc = RESET_PC, if_inst = 0, if_is_c = 0.
//  Output decode (combinational from the queue):
//   - if_is_c = (q[0][1:0] != 2'b11).
//   - if_inst = if_is_c ? {16'h0, q[0]} : {q[1], q[0]}.
//   - if_pc = pc_r.
//   - buffer_stall = (count == 0) | (count == 1 & !if_is_c).
//  Request issue:
//   - imem_en = !flush & (count + 2*inflight + 2 <= DEPTH).
//   - imem_addr = fetch_wa; fetch_wa increments by 1 (modulo 2^ADDR_W) per issued request.
//   - inflight <= imem_en.
//  Push:
//   - When inflight & !flush, push imem_rdata[15:0] then imem_rdata[31:16].
//   - If skip is set, push only [31:16], then clear skip.
//   - Space is guaranteed by the issue rule; no overflow is possible.
//  Pop:
//   - Occurs when if_en & !buffer_stall & !flush.
//   - Removes 1 halfword if if_is_c, else 2.
//   - pc_r advances by 2 or 4 respectively, wrapping modulo 2^32.
//  Ordering:
//   - Push and pop may occur in the same cycle.
//   - Pop uses pre-push contents; no bypass from imem_rdata to outputs.
//  Flush (cycle t):
//   - Queue cleared: count <= 0.
//   - Response arriving in cycle t is discarded.
//   - pc_r <= {flush_target[31:1], 1'b0}.
//   - Target word is requested in the same cycle: imem_en = 1, imem_addr = flush_target[ADDR_W+1:2].
//   - fetch_wa <= target word + 1; skip <= flush_target[1].
//   - Target instruction is presented with buffer_stall = 0 no earlier than cycle t+2.
//   - The remaining halves of a straddling 32-bit target extend this.
//  Stall (if_en = 0): outputs hold; fetching continues until the queue plus in-flight data fills DEPTH.
//  nrst asserted mid-stream: overrides flush and all other events; state returns to reset values next edge.
//   Any response to a pre-reset request is discarded.
//  flush and if_en both high: flush wins; no pop occurs.
// TESTING
//  T1: reset; mem words 0..3 = four 32-bit insts; if_en = 1.
//      -> buffer_stall low from 2nd cycle after reset release; if_pc = 0, 4, 8, 12, each presented once.
//  T2: halfwords 0x0001, 0x0513, 0x0000, 0x4505 at byte 0.
//      -> (pc 0, 0x00000001, c = 1), (pc 2, 0x00000513, c = 0), (pc 6, 0x00004505, c = 1).
//  T3: if_en = 0 for 5 cycles, 32-bit insts.
//      -> outputs stable; imem_en drops once count + 2*inflight = DEPTH; order intact after release.
//  T4: flush to 0x102 while a request is in flight.
//      -> stale word discarded; imem_addr = 0x40 in flush cycle; next presented pc = 0x102; buffer_stall high 2 cycles.
//  T5: 32-bit inst at 0x0E, which straddles two words.
//      -> buffer_stall = 1 while count = 1; inst {hw 0x10, hw 0x0E} presented at pc 0x0E after the next word arrives.
//  T6: nrst pulse mid-stream with flush = 1 and if_en = 1.
//      -> count = 0, if_pc = RESET_PC, buffer_stall = 1, imem_en = 0 for that cycle.

Source files
------------

// File: rtl/inst_aligner.sv
// Fetch-side halfword queue: re-aligns sequential 32-bit memory words into whole
// 16-bit or 32-bit RV32IMC instructions, including 32-bit ones straddling a word.
module inst_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              if_en,
  input  logic              flush,
  input  logic [31:0]       flush_target,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic              if_is_c,
  output logic              buffer_stall
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [15:0]       q_q [DEPTH];
  logic [15:0]       q_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fetch_wa_q, fetch_wa_d;
  logic              inflight_q;
  logic              skip_q, skip_d;
  logic [31:0]       pc_q, pc_d;

  logic              head_c, stall_raw, space_ok, pop, push;
  logic [15:0]       push_hw0, push_hw1;
  int                pop_n, push_n, base;

  // Output decode straight from the queue head; forced to reset values while nrst is high
  assign head_c       = (q_q[0][1:0] != 2'b11);
  assign stall_raw    = (count_q == '0) | ((count_q == CNT_W'(1)) & !head_c);
  assign buffer_stall = nrst | stall_raw;
  assign if_is_c      = !nrst & (count_q != '0) & head_c;
  assign if_pc        = nrst ? RESET_PC : pc_q;
  assign if_inst      = (nrst | (count_q == '0)) ? 32'h0 :
                        head_c ? {16'h0, q_q[0]} : {q_q[1], q_q[0]};

  // Only request when the queue can absorb this word plus any word already in flight
  assign space_ok  = (int'(count_q) + (inflight_q ? 2 : 0) + 2) <= DEPTH;
  assign imem_en   = !nrst & (flush | space_ok);
  assign imem_addr = flush ? flush_target[ADDR_W+1:2] : fetch_wa_q;

  assign pop      = if_en & !stall_raw & !flush;
  assign push     = inflight_q & !flush;
  assign push_hw0 = skip_q ? imem_rdata[31:16] : imem_rdata[15:0];
  assign push_hw1 = imem_rdata[31:16];

  always_comb begin
    pop_n  = pop ? (head_c ? 1 : 2) : 0;
    push_n = push ? (skip_q ? 1 : 2) : 0;
    base   = int'(count_q) - pop_n;
    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = q_q[i];
      if (i + pop_n < int'(count_q))        q_d[i] = q_q[i + pop_n];
      else if (i == base && push_n >= 1)    q_d[i] = push_hw0;
      else if (i == base + 1 && push_n == 2) q_d[i] = push_hw1;
    end

    count_d    = CNT_W'(int'(count_q) - pop_n + push_n);
    pc_d       = pop ? (pc_q + (head_c ? 32'd2 : 32'd4)) : pc_q;
    fetch_wa_d = imem_en ? (fetch_wa_q + ADDR_W'(1)) : fetch_wa_q;
    skip_d     = push ? 1'b0 : skip_q;

    // A redirect empties the queue and restarts fetch at the target word
    if (flush) begin
      count_d    = '0;
      pc_d       = flush_target & ~32'd1;
      fetch_wa_d = flush_target[ADDR_W+1:2] + ADDR_W'(1);
      skip_d     = flush_target[1];
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      skip_q     <= 1'b0;
      pc_q       <= RESET_PC;
      fetch_wa_q <= RESET_PC[ADDR_W+1:2];
    end else begin
      count_q    <= count_d;
      inflight_q <= imem_en;
      skip_q     <= skip_d;
      pc_q       <= pc_d;
      fetch_wa_q <= fetch_wa_d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

endmodule

// File: tb/tb_inst_aligner.sv
// Scoreboard bench for inst_aligner: directed programs, a one-cycle-latency memory
// model, and a negedge monitor that checks every consumed instruction.
module tb_inst_aligner;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        if_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = 32'h0;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = 32'hFFFF_FFFF;
  logic [31:0] if_inst, if_pc;
  logic        if_is_c, buffer_stall;

  inst_aligner #(.RESET_PC(32'h0), .ADDR_W(12), .DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .if_en(if_en), .flush(flush), .flush_target(flush_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc(if_pc), .if_is_c(if_is_c), .buffer_stall(buffer_stall)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  always @(posedge clk) imem_rdata <= imem_en ? mem[imem_addr] : 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        c;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] W0 = 32'h0010_0093, W1 = 32'h0020_0113,
                          W2 = 32'h0030_0193, W3 = 32'h0040_0213;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst, input logic c);
    exp_t e;
    e.pc = pc; e.inst = inst; e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: every instruction the DUT hands over must be the next one expected
  always @(negedge clk) begin
    if (!nrst && !flush && if_en && !buffer_stall) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h, none expected", if_pc, if_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_pc", if_pc, e.pc);
        check("mon_inst", if_inst, e.inst);
        check("mon_is_c", {31'h0, if_is_c}, {31'h0, e.c});
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load_words;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0000_0013;
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
  endtask

  task automatic do_reset(input bit chk);
    nrst = 1'b1; flush = 1'b0; if_en = 1'b0;
    @(negedge clk);
    if (chk) begin
      check("rst_stall", {31'h0, buffer_stall}, 32'd1);
      check("rst_imem_en", {31'h0, imem_en}, 32'd0);
      check("rst_pc", if_pc, 32'h0);
      check("rst_inst", if_inst, 32'h0);
      check("rst_is_c", {31'h0, if_is_c}, 32'd0);
    end
    tick;
    nrst = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    do begin
      tick; k++;
    end while (sb.size() != 0 && k < budget);
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", nm, sb.size());
      sb.delete();
    end
    if_en = 1'b0;
  endtask

  initial begin
    load_words();
    repeat (2) tick;

    // T1: four aligned 32-bit instructions
    do_reset(1);
    if_en = 1'b1;
    expect_inst(32'h0, W0, 1'b0); expect_inst(32'h4, W1, 1'b0);
    expect_inst(32'h8, W2, 1'b0); expect_inst(32'hC, W3, 1'b0);
    @(negedge clk);
    check("t1_stall_r0", {31'h0, buffer_stall}, 32'd1);
    check("t1_imem_addr_r0", {20'h0, imem_addr}, 32'h0);
    tick; @(negedge clk);
    check("t1_stall_r1", {31'h0, buffer_stall}, 32'd1);
    tick; @(negedge clk);
    check("t1_stall_r2", {31'h0, buffer_stall}, 32'd0);
    drain("t1", 20);

    // T2: mixed compressed / 32-bit / compressed
    load_words();
    mem[0] = 32'h0513_0001; mem[1] = 32'h4505_0000; mem[2] = 32'h0001_0001;
    do_reset(0);
    if_en = 1'b1;
    expect_inst(32'h0, 32'h0000_0001, 1'b1);
    expect_inst(32'h2, 32'h0000_0513, 1'b0);
    expect_inst(32'h6, 32'h0000_4505, 1'b1);
    drain("t2", 20);

    // T3: hold if_en low for five cycles, fetch must stop at a full queue
    load_words();
    do_reset(0);
    expect_inst(32'h0, W0, 1'b0); expect_inst(32'h4, W1, 1'b0);
    expect_inst(32'h8, W2, 1'b0); expect_inst(32'hC, W3, 1'b0);
    @(negedge clk); check("t3_en_r0", {31'h0, imem_en}, 32'd1);
    tick; @(negedge clk); check("t3_en_r1", {31'h0, imem_en}, 32'd1);
    tick; @(negedge clk); check("t3_en_r2", {31'h0, imem_en}, 32'd0);
    for (int r = 3; r < 5; r++) begin
      tick; @(negedge clk);
      check("t3_en_full", {31'h0, imem_en}, 32'd0);
      check("t3_hold_pc", if_pc, 32'h0);
      check("t3_hold_inst", if_inst, W0);
      check("t3_hold_stall", {31'h0, buffer_stall}, 32'd0);
    end
    tick;
    if_en = 1'b1;
    drain("t3", 20);

    // T4: redirect to 0x102 (bit 0 set, must be ignored) with a word in flight
    load_words();
    mem[12'h40] = 32'h4505_FFFF; mem[12'h41] = 32'h0001_0001;
    do_reset(0);
    tick;
    flush = 1'b1; flush_target = 32'h0000_0103;
    expect_inst(32'h102, 32'h0000_4505, 1'b1);
    expect_inst(32'h104, 32'h0000_0001, 1'b1);
    expect_inst(32'h106, 32'h0000_0001, 1'b1);
    @(negedge clk);
    check("t4_flush_en", {31'h0, imem_en}, 32'd1);
    check("t4_flush_addr", {20'h0, imem_addr}, 32'h40);
    check("t4_stall_t0", {31'h0, buffer_stall}, 32'd1);
    tick;
    flush = 1'b0; if_en = 1'b1;
    @(negedge clk); check("t4_stall_t1", {31'h0, buffer_stall}, 32'd1);
    tick; @(negedge clk);
    check("t4_stall_t2", {31'h0, buffer_stall}, 32'd0);
    check("t4_pc_t2", if_pc, 32'h102);
    drain("t4", 20);

    // T5: 32-bit instruction at 0x0E straddling words 3 and 4
    load_words();
    mem[3] = 32'h0093_FFFF; mem[4] = 32'h0001_0010;
    do_reset(0);
    flush = 1'b1; flush_target = 32'h0000_000E;
    expect_inst(32'h0E, 32'h0010_0093, 1'b0);
    expect_inst(32'h12, 32'h0000_0001, 1'b1);
    @(negedge clk); check("t5_flush_addr", {20'h0, imem_addr}, 32'h3);
    tick;
    flush = 1'b0; if_en = 1'b1;
    @(negedge clk); check("t5_stall_t1", {31'h0, buffer_stall}, 32'd1);
    tick; @(negedge clk); check("t5_stall_half", {31'h0, buffer_stall}, 32'd1);
    tick; @(negedge clk);
    check("t5_stall_t3", {31'h0, buffer_stall}, 32'd0);
    check("t5_pc_t3", if_pc, 32'h0E);
    drain("t5", 20);

    // T6: reset pulse mid-stream together with flush and if_en
    load_words();
    mem[4] = 32'h0050_0293; mem[5] = 32'h0060_0313;
    do_reset(0);
    if_en = 1'b1;
    expect_inst(32'h0, W0, 1'b0); expect_inst(32'h4, W1, 1'b0);
    expect_inst(32'h8, W2, 1'b0); expect_inst(32'hC, W3, 1'b0);
    for (int k = 0; k < 20 && sb.size() > 2; k++) tick;
    check("t6_reached_mid", sb.size(), 32'd2);
    nrst = 1'b1; flush = 1'b1; flush_target = 32'h0000_0200;
    @(negedge clk);
    check("t6_rst_en", {31'h0, imem_en}, 32'd0);
    check("t6_rst_stall", {31'h0, buffer_stall}, 32'd1);
    check("t6_rst_pc", if_pc, 32'h0);
    sb.delete();
    tick;
    nrst = 1'b0; flush = 1'b0; if_en = 1'b0;
    @(negedge clk);
    check("t6_after_stall", {31'h0, buffer_stall}, 32'd1);
    check("t6_after_pc", if_pc, 32'h0);
    check("t6_after_en", {31'h0, imem_en}, 32'd1);
    check("t6_after_addr", {20'h0, imem_addr}, 32'h0);
    tick;
    expect_inst(32'h0, W0, 1'b0); expect_inst(32'h4, W1, 1'b0);
    if_en = 1'b1;
    drain("t6", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
